pipe_ctrl: RTL and testbench

Parametrised pipeline stall/flush controller for the in-order core pipeline: PC, IF/ID, ID/EXE, EXE/MEM, MEM/WB.
- Detects load-use hazards in ID, redirects the PC on taken branches resolved in EXE, and freezes the pipeline while the data RAM is busy.
- Tracks a per-register valid bit and keeps saturating stall/flush performance counters.
- Sits beside the pipeline in the core top. It drives the stall/flush inputs of every pipeline register and the redirect input of pc_reg.

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/pipe_ctrl_if.sv | 52 +++++
 rtl/pipe_ctrl_hazard_det.sv | 34 +++
 rtl/pipe_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/flush controller: controller FSM
// state encoding, pipeline register index constants and default bus widths.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

   // Default PC and register-address widths of the core.
   localparam int unsigned ADDR_WIDTH  = 32;
   localparam int unsigned RADDR_WIDTH = 5;

   // Pipeline register indices as seen on stall_o / flush_o / valid_o.
   localparam int unsigned STG_PC     = 0;
   localparam int unsigned STG_IFID   = 1;
   localparam int unsigned STG_IDEXE  = 2;
   localparam int unsigned STG_EXEMEM = 3;
   localparam int unsigned STG_MEMWB  = 4;

   typedef enum logic [0:0] {
      StRun     = 1'b0,
      StMemWait = 1'b1
   } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
// Bundle of every signal exchanged between the core pipeline and pipe_ctrl.
//   master : pipeline side (drives hazard/branch/memory status, receives controls)
//   slave  : controller side (pipe_ctrl)
// -----------------------------------------------------------------------------
interface pipe_ctrl_if #(
   parameter int unsigned STAGES      = 5,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned RADDR_WIDTH = 5,
   parameter int unsigned CNT_WIDTH   = 16
);

   // Pipeline status into the controller.
   logic                   id_reg1_re_i;
   logic [RADDR_WIDTH-1:0] id_reg1_raddr_i;
   logic                   id_reg2_re_i;
   logic [RADDR_WIDTH-1:0] id_reg2_raddr_i;
   logic                   exe_is_load_i;
   logic                   exe_reg_we_i;
   logic [RADDR_WIDTH-1:0] exe_reg_waddr_i;
   logic                   branch_taken_i;
   logic [ADDR_WIDTH-1:0]  branch_target_i;
   logic                   mem_busy_i;

   // Controls and status back to the pipeline.
   logic [STAGES-1:0]      stall_o;
   logic [STAGES-1:0]      flush_o;
   logic                   pc_we_o;
   logic [ADDR_WIDTH-1:0]  pc_o;
   logic [STAGES-1:0]      valid_o;
   logic [CNT_WIDTH-1:0]   stall_cnt_o;
   logic [CNT_WIDTH-1:0]   flush_cnt_o;
   logic                   err_o;

   modport master (
      output id_reg1_re_i, id_reg1_raddr_i, id_reg2_re_i, id_reg2_raddr_i,
      output exe_is_load_i, exe_reg_we_i, exe_reg_waddr_i,
      output branch_taken_i, branch_target_i, mem_busy_i,
      input  stall_o, flush_o, pc_we_o, pc_o, valid_o,
      input  stall_cnt_o, flush_cnt_o, err_o
   );

   modport slave (
      input  id_reg1_re_i, id_reg1_raddr_i, id_reg2_re_i, id_reg2_raddr_i,
      input  exe_is_load_i, exe_reg_we_i, exe_reg_waddr_i,
      input  branch_taken_i, branch_target_i, mem_busy_i,
      output stall_o, flush_o, pc_we_o, pc_o, valid_o,
      output stall_cnt_o, flush_cnt_o, err_o
   );

endinterface

// File: rtl/pipe_ctrl_hazard_det.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_hazard_det
// Purely combinational load-use comparator: flags when the instruction in ID
// reads a register that the load currently in EXE will write.
//   i_rs1_re / i_rs1_raddr   : ID source 1 read enable / address
//   i_rs2_re / i_rs2_raddr   : ID source 2 read enable / address
//   i_exe_is_load            : EXE holds a load
//   i_exe_reg_we / _waddr    : EXE register-file write enable / destination
//   o_load_use               : hazard present
// -----------------------------------------------------------------------------
module pipe_ctrl_hazard_det #(
   parameter int unsigned RADDR_WIDTH = 5
) (
   input  logic                   i_rs1_re,
   input  logic [RADDR_WIDTH-1:0] i_rs1_raddr,
   input  logic                   i_rs2_re,
   input  logic [RADDR_WIDTH-1:0] i_rs2_raddr,
   input  logic                   i_exe_is_load,
   input  logic                   i_exe_reg_we,
   input  logic [RADDR_WIDTH-1:0] i_exe_reg_waddr,
   output logic                   o_load_use
);

   logic w_rs1_hit;
   logic w_rs2_hit;
   logic w_dst_live;

   // x0 is hardwired to zero, so a load targeting it never produces data.
   assign w_dst_live = i_exe_is_load & i_exe_reg_we & (i_exe_reg_waddr != '0);
   assign w_rs1_hit  = i_rs1_re & (i_rs1_raddr == i_exe_reg_waddr);
   assign w_rs2_hit  = i_rs2_re & (i_rs2_raddr == i_exe_reg_waddr);
   assign o_load_use = w_dst_live & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Stall/flush controller for the in-order pipeline (PC, IF/ID, ID/EXE, ...).
// Priority of responses: memory busy > taken branch > load-use hazard.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-low reset
//   bus_io  : pipe_ctrl_if.slave
//             in : ID read ports, EXE load/write info, branch, mem_busy_i
//             out: stall_o, flush_o, pc_we_o, pc_o (combinational),
//                  valid_o, stall_cnt_o, flush_cnt_o, err_o (registered)
// -----------------------------------------------------------------------------
module pipe_ctrl #(
   parameter int unsigned STAGES      = 5,
   parameter int unsigned BR_REG      = 2,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned RADDR_WIDTH = 5,
   parameter int unsigned TIMEOUT     = 255,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   pipe_ctrl_if.slave bus_io
);

   import pipe_ctrl_pkg::*;

   localparam int unsigned         TW     = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]       TO_MAX = TW'(TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_e                 r_state_q, w_state_d;
   logic [TW-1:0]          r_to_cnt_q, w_to_cnt_d;
   logic                   r_err_q, w_err_d;
   logic [STAGES-1:0]      r_valid_q, w_valid_d;
   logic [CNT_WIDTH-1:0]   r_stall_cnt_q, w_stall_cnt_d;
   logic [CNT_WIDTH-1:0]   r_flush_cnt_q, w_flush_cnt_d;

   logic                   w_load_use;
   logic [STAGES-1:0]      w_stall;
   logic [STAGES-1:0]      w_flush;
   logic                   w_pc_we;
   logic [ADDR_WIDTH-1:0]  w_pc;
   logic [STAGES-1:0]      w_fill;

   pipe_ctrl_hazard_det #(
      .RADDR_WIDTH (RADDR_WIDTH)
   ) u_hazard_det (
      .i_rs1_re        (bus_io.id_reg1_re_i),
      .i_rs1_raddr     (bus_io.id_reg1_raddr_i),
      .i_rs2_re        (bus_io.id_reg2_re_i),
      .i_rs2_raddr     (bus_io.id_reg2_raddr_i),
      .i_exe_is_load   (bus_io.exe_is_load_i),
      .i_exe_reg_we    (bus_io.exe_reg_we_i),
      .i_exe_reg_waddr (bus_io.exe_reg_waddr_i),
      .o_load_use      (w_load_use)
   );

   // Pipeline controls. Reset forces every register to a bubble.
   always_comb begin
      w_stall = '0;
      w_flush = '0;
      w_pc_we = 1'b0;
      w_pc    = '0;
      if (!rst_i) begin
         w_flush = '1;
      end else if (bus_io.mem_busy_i) begin
         // Freeze everything up to MEM; the last register drains as a bubble.
         // A pending branch stays frozen in EXE and redirects once RAM is done.
         w_stall[STAGES-2:0] = '1;
         w_flush[STAGES-1]   = 1'b1;
      end else if (bus_io.branch_taken_i) begin
         // Wrong-path instructions behind the branch are squashed, which also
         // removes any load-use consumer, so the hazard is ignored here.
         w_pc_we           = 1'b1;
         w_pc              = bus_io.branch_target_i;
         w_flush[BR_REG:1] = '1;
      end else if (w_load_use) begin
         w_stall[STG_IFID:STG_PC] = '1;
         w_flush[STG_IDEXE]       = 1'b1;
      end
   end

   assign bus_io.stall_o = w_stall;
   assign bus_io.flush_o = w_flush;
   assign bus_io.pc_we_o = w_pc_we;
   assign bus_io.pc_o    = w_pc;

   // Memory-wait FSM and timeout; the counter value equals the number of
   // consecutive busy cycles seen so far.
   always_comb begin
      w_state_d  = r_state_q;
      w_to_cnt_d = r_to_cnt_q;
      w_err_d    = r_err_q;
      unique case (r_state_q)
         StRun: begin
            if (bus_io.mem_busy_i) begin
               w_state_d  = StMemWait;
               w_to_cnt_d = TW'(1);
            end
         end
         StMemWait: begin
            if (!bus_io.mem_busy_i) begin
               w_state_d = StRun;
            end else if (r_to_cnt_q != TO_MAX) begin
               w_to_cnt_d = r_to_cnt_q + TW'(1);
            end
         end
         default: w_state_d = StRun;
      endcase
      if (bus_io.mem_busy_i && (w_to_cnt_d == TO_MAX)) begin
         w_err_d = 1'b1;
      end
   end

   // Valid bits advance one register per cycle unless held or squashed.
   assign w_fill = {r_valid_q[STAGES-2:0], 1'b1};

   always_comb begin
      w_valid_d = r_valid_q;
      for (int i = 0; i < STAGES; i++) begin
         if (w_flush[i]) begin
            w_valid_d[i] = 1'b0;
         end else if (!w_stall[i]) begin
            w_valid_d[i] = w_fill[i];
         end
      end
   end

   // Saturating performance counters.
   always_comb begin
      w_stall_cnt_d = r_stall_cnt_q;
      w_flush_cnt_d = r_flush_cnt_q;
      if ((|w_stall) && (r_stall_cnt_q != CNT_MAX)) begin
         w_stall_cnt_d = r_stall_cnt_q + CNT_WIDTH'(1);
      end
      if (w_pc_we && (r_flush_cnt_q != CNT_MAX)) begin
         w_flush_cnt_d = r_flush_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state_q     <= StRun;
         r_to_cnt_q    <= '0;
         r_err_q       <= 1'b0;
         r_valid_q     <= '0;
         r_stall_cnt_q <= '0;
         r_flush_cnt_q <= '0;
      end else begin
         r_state_q     <= w_state_d;
         r_to_cnt_q    <= w_to_cnt_d;
         r_err_q       <= w_err_d;
         r_valid_q     <= w_valid_d;
         r_stall_cnt_q <= w_stall_cnt_d;
         r_flush_cnt_q <= w_flush_cnt_d;
      end
   end

   assign bus_io.valid_o     = r_valid_q;
   assign bus_io.stall_cnt_o = r_stall_cnt_q;
   assign bus_io.flush_cnt_o = r_flush_cnt_q;
   assign bus_io.err_o       = r_err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed bench for pipe_ctrl: STAGES=5, BR_REG=2, TIMEOUT=4, CNT_WIDTH=4.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   pipe_ctrl_if #(
      .STAGES      (5),
      .ADDR_WIDTH  (32),
      .RADDR_WIDTH (5),
      .CNT_WIDTH   (4)
   ) bus ();

   pipe_ctrl #(
      .STAGES      (5),
      .BR_REG      (2),
      .ADDR_WIDTH  (32),
      .RADDR_WIDTH (5),
      .TIMEOUT     (4),
      .CNT_WIDTH   (4)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst_n),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic [4:0] stall, input logic [4:0] flush,
                          input logic pc_we, input logic [31:0] pc);
      chk({tag, "_stall"}, 32'(bus.stall_o), 32'(stall));
      chk({tag, "_flush"}, 32'(bus.flush_o), 32'(flush));
      chk({tag, "_pc_we"}, 32'(bus.pc_we_o), 32'(pc_we));
      chk({tag, "_pc"}, bus.pc_o, pc);
   endtask

   task automatic clear();
      bus.id_reg1_re_i    = 1'b0;
      bus.id_reg1_raddr_i = '0;
      bus.id_reg2_re_i    = 1'b0;
      bus.id_reg2_raddr_i = '0;
      bus.exe_is_load_i   = 1'b0;
      bus.exe_reg_we_i    = 1'b0;
      bus.exe_reg_waddr_i = '0;
      bus.branch_taken_i  = 1'b0;
      bus.branch_target_i = '0;
      bus.mem_busy_i      = 1'b0;
   endtask

   task automatic set_load_use(input logic [4:0] waddr, input logic [4:0] raddr1);
      bus.exe_is_load_i   = 1'b1;
      bus.exe_reg_we_i    = 1'b1;
      bus.exe_reg_waddr_i = waddr;
      bus.id_reg1_re_i    = 1'b1;
      bus.id_reg1_raddr_i = raddr1;
   endtask

   logic [4:0] exp_fill [6];

   initial begin
      n_checks = 0;
      n_fail   = 0;
      exp_fill = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b11111};
      rst_n    = 1'b0;
      clear();
      // Reset dominates active inputs.
      bus.branch_taken_i  = 1'b1;
      bus.branch_target_i = 32'h40;
      bus.mem_busy_i      = 1'b1;
      repeat (2) tick();
      chk_ctl("reset", 5'b00000, 5'b11111, 1'b0, 32'h0);
      chk("reset_valid", 32'(bus.valid_o), 32'h0);
      chk("reset_stall_cnt", 32'(bus.stall_cnt_o), 32'h0);
      chk("reset_flush_cnt", 32'(bus.flush_cnt_o), 32'h0);
      chk("reset_err", 32'(bus.err_o), 32'h0);

      // 1: release, valid fills one bit per cycle.
      clear();
      rst_n = 1'b1;
      #1;
      chk_ctl("idle", 5'b00000, 5'b00000, 1'b0, 32'h0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("fill_valid", 32'(bus.valid_o), 32'(exp_fill[i]));
      end

      // 2: load-use on rs1.
      set_load_use(5'd5, 5'd5);
      #1;
      chk_ctl("lu_rs1", 5'b00011, 5'b00100, 1'b0, 32'h0);
      tick();
      chk("lu_rs1_valid", 32'(bus.valid_o), 32'h1b);
      chk("lu_rs1_stall_cnt", 32'(bus.stall_cnt_o), 32'd1);

      // 3: non-hazards, then a hazard via rs2.
      set_load_use(5'd0, 5'd0);
      #1;
      chk_ctl("x0", 5'b00000, 5'b00000, 1'b0, 32'h0);
      set_load_use(5'd5, 5'd5);
      bus.id_reg1_re_i = 1'b0;
      #1;
      chk_ctl("re_off", 5'b00000, 5'b00000, 1'b0, 32'h0);
      set_load_use(5'd5, 5'd5);
      bus.exe_is_load_i = 1'b0;
      #1;
      chk("not_load_stall", 32'(bus.stall_o), 32'h0);
      set_load_use(5'd5, 5'd5);
      bus.exe_reg_we_i = 1'b0;
      #1;
      chk("we_off_stall", 32'(bus.stall_o), 32'h0);
      set_load_use(5'd7, 5'd5);
      bus.id_reg2_re_i    = 1'b1;
      bus.id_reg2_raddr_i = 5'd7;
      #1;
      chk_ctl("lu_rs2", 5'b00011, 5'b00100, 1'b0, 32'h0);
      tick();
      chk("lu_rs2_valid", 32'(bus.valid_o), 32'h13);
      chk("lu_rs2_stall_cnt", 32'(bus.stall_cnt_o), 32'd2);
      clear();
      tick();
      chk("refill_valid", 32'(bus.valid_o), 32'h07);

      // 4: branch with concurrent load-use.
      set_load_use(5'd5, 5'd5);
      bus.branch_taken_i  = 1'b1;
      bus.branch_target_i = 32'h0000_0040;
      #1;
      chk_ctl("branch", 5'b00000, 5'b00110, 1'b1, 32'h40);
      tick();
      chk("branch_valid", 32'(bus.valid_o), 32'h09);
      chk("branch_flush_cnt", 32'(bus.flush_cnt_o), 32'd1);
      chk("branch_stall_cnt", 32'(bus.stall_cnt_o), 32'd2);

      // 5: branch frozen behind 3 busy cycles.
      clear();
      bus.mem_busy_i      = 1'b1;
      bus.branch_taken_i  = 1'b1;
      bus.branch_target_i = 32'h80;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk_ctl("busy_br", 5'b01111, 5'b10000, 1'b0, 32'h0);
         tick();
         chk("busy_valid", 32'(bus.valid_o), 32'h09);
         chk("busy_stall_cnt", 32'(bus.stall_cnt_o), 32'(3 + i));
      end
      chk("busy3_err", 32'(bus.err_o), 32'h0);
      bus.mem_busy_i = 1'b0;
      #1;
      chk_ctl("br_release", 5'b00000, 5'b00110, 1'b1, 32'h80);
      tick();
      chk("br_release_flush_cnt", 32'(bus.flush_cnt_o), 32'd2);
      chk("br_release_valid", 32'(bus.valid_o), 32'h11);
      chk("br_release_err", 32'(bus.err_o), 32'h0);

      // 6: timeout after 4 busy cycles, sticky, then async reset mid-stall.
      clear();
      bus.mem_busy_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("timeout_err", 32'(bus.err_o), (i >= 3) ? 32'h1 : 32'h0);
      end
      chk("timeout_stall_cnt", 32'(bus.stall_cnt_o), 32'd11);
      bus.mem_busy_i = 1'b0;
      tick();
      chk("timeout_err_sticky", 32'(bus.err_o), 32'h1);
      bus.mem_busy_i     = 1'b1;
      bus.branch_taken_i = 1'b1;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk_ctl("async_rst", 5'b00000, 5'b11111, 1'b0, 32'h0);
      chk("async_rst_valid", 32'(bus.valid_o), 32'h0);
      chk("async_rst_err", 32'(bus.err_o), 32'h0);
      chk("async_rst_stall_cnt", 32'(bus.stall_cnt_o), 32'h0);
      chk("async_rst_flush_cnt", 32'(bus.flush_cnt_o), 32'h0);
      tick();
      clear();
      rst_n = 1'b1;

      // 7: counter saturation at 4'hf.
      bus.mem_busy_i = 1'b1;
      repeat (17) tick();
      chk("stall_cnt_sat", 32'(bus.stall_cnt_o), 32'hf);
      bus.mem_busy_i     = 1'b0;
      bus.branch_taken_i = 1'b1;
      repeat (17) tick();
      chk("flush_cnt_sat", 32'(bus.flush_cnt_o), 32'hf);
      chk("stall_cnt_hold", 32'(bus.stall_cnt_o), 32'hf);
      clear();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
